udp_stream_rx: RTL

Receive-side counterpart of the 64-bit IPv4/UDP stream generator. Consumes raw IPv4+UDP packets on a 64-bit AXI4-Stream slave and validates the IP/UDP headers. Strips the 28-byte header and emits the realigned UDP payload on a 64-bit AXI4-Stream master. Keeps good/dropped packet counters for the PS register block.

---
 rtl/udp_stream_rx.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/udp_stream_rx.sv
// IPv4/UDP receive path: validates a 28-byte IP+UDP header on a 64-bit stream,
// strips it, realigns the payload by 4 bytes and counts good/dropped packets.
module udp_stream_rx #(
  parameter logic [31:0] LOCAL_IP   = 32'hC0A80401,
  parameter logic [15:0] LOCAL_PORT = 16'h303A,
  parameter bit          CHECK_CSUM = 1'b1
) (
  input  logic        m00_axis_aclk,
  input  logic        m00_axis_aresetn,
  input  logic [63:0] s00_axis_tdata,
  input  logic [7:0]  s00_axis_tkeep,
  input  logic        s00_axis_tvalid,
  input  logic        s00_axis_tlast,
  output logic        s00_axis_tready,
  output logic [63:0] m00_axis_tdata,
  output logic [7:0]  m00_axis_tkeep,
  output logic        m00_axis_tvalid,
  output logic        m00_axis_tlast,
  input  logic        m00_axis_tready,
  output logic [31:0] rx_good_count,
  output logic [31:0] rx_drop_count
);

  localparam logic [1:0] S_HDR     = 2'd0;
  localparam logic [1:0] S_PAYLOAD = 2'd1;
  localparam logic [1:0] S_FLUSH   = 2'd2;
  localparam logic [1:0] S_DROP    = 2'd3;

  logic [1:0]       state;
  logic [1:0]       beat_idx;
  logic             hdr_ok;
  logic [19:0]      csum_acc;
  logic [31:0]      held;
  logic [3:0]       held_keep;
  logic             in_fire;
  logic             out_free;
  logic [3:0][15:0] be_word;
  logic [17:0]      beat_sum;
  logic             beat_ok;
  logic [16:0]      fold1;
  logic [15:0]      fold2;
  logic             csum_pass;
  logic             hdr_pass;
  logic [31:0]      dst_ip;
  logic [15:0]      dst_port;

  assign in_fire  = s00_axis_tvalid & s00_axis_tready;
  assign out_free = ~m00_axis_tvalid | m00_axis_tready;

  // Header words are big-endian: lane 2g is the high byte of word g.
  for (genvar g = 0; g < 4; g++) begin : g_word
    assign be_word[g] = {s00_axis_tdata[16*g +: 8], s00_axis_tdata[16*g+8 +: 8]};
  end

  assign dst_ip   = {s00_axis_tdata[7:0], s00_axis_tdata[15:8],
                     s00_axis_tdata[23:16], s00_axis_tdata[31:24]};
  assign dst_port = {s00_axis_tdata[55:48], s00_axis_tdata[63:56]};

  // w2 carries only two IP header words; its upper lanes are UDP.
  always_comb begin
    beat_sum = 18'(be_word[0]) + 18'(be_word[1]);
    if (beat_idx != 2'd2)
      beat_sum = beat_sum + 18'(be_word[2]) + 18'(be_word[3]);
  end

  always_comb begin
    beat_ok = 1'b1;
    case (beat_idx)
      2'd0:    beat_ok = (s00_axis_tdata[7:0] == 8'h45);
      2'd1:    beat_ok = (s00_axis_tdata[15:8] == 8'h11);
      2'd2:    beat_ok = (dst_ip == LOCAL_IP) && (dst_port == LOCAL_PORT);
      default: beat_ok = 1'b1;
    endcase
  end

  // Two end-around folds bring the 20-bit sum back to a 16-bit one's-complement value.
  assign fold1     = {1'b0, csum_acc[15:0]} + {13'd0, csum_acc[19:16]};
  assign fold2     = fold1[15:0] + {15'd0, fold1[16]};
  assign csum_pass = (CHECK_CSUM == 1'b0) || (fold2 == 16'hFFFF);
  assign hdr_pass  = hdr_ok & csum_pass;

  always_comb begin
    case (state)
      S_PAYLOAD: s00_axis_tready = out_free;
      S_FLUSH:   s00_axis_tready = 1'b0;
      default:   s00_axis_tready = 1'b1;
    endcase
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state         <= S_HDR;
      beat_idx      <= 2'd0;
      hdr_ok        <= 1'b0;
      csum_acc      <= 20'd0;
      held          <= 32'd0;
      held_keep     <= 4'd0;
      rx_good_count <= 32'd0;
      rx_drop_count <= 32'd0;
    end else begin
      case (state)
        S_HDR: if (in_fire) begin
          if (beat_idx != 2'd3) begin
            hdr_ok   <= ((beat_idx == 2'd0) ? 1'b1 : hdr_ok) & beat_ok;
            csum_acc <= ((beat_idx == 2'd0) ? 20'd0 : csum_acc) + 20'(beat_sum);
            if (s00_axis_tlast) begin
              rx_drop_count <= rx_drop_count + 32'd1;
              beat_idx      <= 2'd0;
            end else begin
              beat_idx <= beat_idx + 2'd1;
            end
          end else begin
            beat_idx <= 2'd0;
            if (!hdr_pass) begin
              rx_drop_count <= rx_drop_count + 32'd1;
              state         <= s00_axis_tlast ? S_HDR : S_DROP;
            end else begin
              rx_good_count <= rx_good_count + 32'd1;
              held          <= s00_axis_tdata[63:32];
              held_keep     <= s00_axis_tkeep[7:4];
              if (!s00_axis_tlast)
                state <= S_PAYLOAD;
              else if (s00_axis_tkeep[7:4] != 4'd0)
                state <= S_FLUSH;
            end
          end
        end
        S_PAYLOAD: if (in_fire) begin
          held      <= s00_axis_tdata[63:32];
          held_keep <= s00_axis_tkeep[7:4];
          if (s00_axis_tlast)
            state <= (s00_axis_tkeep[7:4] == 4'd0) ? S_HDR : S_FLUSH;
        end
        S_FLUSH: if (out_free) state <= S_HDR;
        default: if (in_fire && s00_axis_tlast) state <= S_HDR;
      endcase
    end
  end

  // Single output stage; a PAYLOAD input beat only fires when this register is free.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= 64'd0;
      m00_axis_tkeep  <= 8'd0;
      m00_axis_tlast  <= 1'b0;
    end else if (state == S_PAYLOAD && in_fire) begin
      m00_axis_tvalid <= 1'b1;
      m00_axis_tdata  <= {s00_axis_tdata[31:0], held};
      m00_axis_tkeep  <= {s00_axis_tkeep[3:0], 4'hF};
      m00_axis_tlast  <= s00_axis_tlast && (s00_axis_tkeep[7:4] == 4'd0);
    end else if (state == S_FLUSH && out_free) begin
      m00_axis_tvalid <= 1'b1;
      m00_axis_tdata  <= {32'd0, held};
      m00_axis_tkeep  <= {4'd0, held_keep};
      m00_axis_tlast  <= 1'b1;
    end else if (m00_axis_tready) begin
      m00_axis_tvalid <= 1'b0;
    end
  end

endmodule
